// File: rtl/zacore_mem_pkg.sv
// Shared types and the round-robin pick helper for the Zacore memory-port arbiter.
// Payload and channel-ID type widths follow the ZM_* defaults below.
package zacore_mem_pkg;

  localparam int ZM_NUM_CH    = 2;
  localparam int ZM_ADDR_W    = 32;
  localparam int ZM_DATA_W    = 32;
  localparam int ZM_MAX_OUTST = 4;
  localparam int ZM_MASK_W    = ZM_DATA_W / 8;
  localparam int ZM_CH_W      = (ZM_NUM_CH > 1) ? $clog2(ZM_NUM_CH) : 1;
  localparam int ZM_MAX_CH    = 32;

  typedef logic [ZM_CH_W-1:0] ch_id_t;

  typedef struct packed {
    logic                 write;
    logic [ZM_ADDR_W-1:0] addr;
    logic [ZM_DATA_W-1:0] wdata;
    logic [ZM_MASK_W-1:0] wmask;
  } mem_req_t;

  // One-hot winner: first valid channel searching upward from last+1, wrapping at n.
  function automatic logic [ZM_MAX_CH-1:0] rr_pick(
    input logic [ZM_MAX_CH-1:0] vld,
    input int unsigned          last,
    input int unsigned          n
  );
    logic [ZM_MAX_CH-1:0] gnt;
    int unsigned          idx;
    gnt = '0;
    for (int unsigned k = 1; k <= ZM_MAX_CH; k++) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      if ((k <= n) && (gnt == '0) && vld[idx[4:0]]) gnt[idx[4:0]] = 1'b1;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/zacore_mem_arbiter_if.sv
// Request, response and memory-side bundle of the arbiter; the slave modport is the
// arbiter's own view, the master modport is the requesters/memory side.
interface zacore_mem_arbiter_if
  import zacore_mem_pkg::*;
#(
  parameter int NUM_CH = ZM_NUM_CH,
  parameter int ADDR_W = ZM_ADDR_W,
  parameter int DATA_W = ZM_DATA_W
);
  localparam int MASK_W = DATA_W / 8;

  logic [NUM_CH-1:0]        i_req_valid;
  logic [NUM_CH-1:0]        o_req_ready;
  logic [NUM_CH-1:0]        i_req_write;
  logic [NUM_CH*ADDR_W-1:0] i_req_addr;
  logic [NUM_CH*DATA_W-1:0] i_req_wdata;
  logic [NUM_CH*MASK_W-1:0] i_req_wmask;
  logic [NUM_CH-1:0]        o_rsp_valid;
  logic [DATA_W-1:0]        o_rsp_rdata;
  logic                     o_mem_valid;
  logic                     i_mem_ready;
  logic                     o_mem_write;
  logic [ADDR_W-1:0]        o_mem_addr;
  logic [DATA_W-1:0]        o_mem_wdata;
  logic [MASK_W-1:0]        o_mem_wmask;
  logic                     i_mem_rsp_valid;
  logic [DATA_W-1:0]        i_mem_rdata;
  logic                     o_err;

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_wmask,
    input  i_mem_ready, i_mem_rsp_valid, i_mem_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_rdata,
    output o_mem_valid, o_mem_write, o_mem_addr, o_mem_wdata, o_mem_wmask, o_err
  );

  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_wmask,
    output i_mem_ready, i_mem_rsp_valid, i_mem_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata,
    input  o_mem_valid, o_mem_write, o_mem_addr, o_mem_wdata, o_mem_wmask, o_err
  );

endinterface

// File: rtl/zacore_tag_fifo.sv
// Channel-ID FIFO tracking outstanding requests in issue order; head is read combinationally.
// Push when full and pop when empty are ignored; simultaneous push/pop keeps the count.
module zacore_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int             PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/zacore_mem_arbiter.sv
// Round-robin merge of NUM_CH requesters onto one in-order memory port; request and response
// each take one registered cycle. Holds o_mem_* while stalled, no grant when MAX_OUTST in flight.
module zacore_mem_arbiter
  import zacore_mem_pkg::*;
#(
  parameter int NUM_CH    = ZM_NUM_CH,
  parameter int ADDR_W    = ZM_ADDR_W,
  parameter int DATA_W    = ZM_DATA_W,
  parameter int MAX_OUTST = ZM_MAX_OUTST
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  zacore_mem_arbiter_if.slave  bus
);
  localparam int MASK_W = DATA_W / 8;

  mem_req_t             req_q;
  mem_req_t             req_d;
  logic                 mem_valid_q;
  logic                 run_q;
  logic                 err_q;
  logic [NUM_CH-1:0]    rsp_valid_q;
  logic [DATA_W-1:0]    rsp_rdata_q;
  ch_id_t               last_grant_q;
  ch_id_t               gnt_id;
  ch_id_t               fifo_head;
  logic [NUM_CH-1:0]    gnt_oh;
  logic [ZM_MAX_CH-1:0] vld_ext;
  logic [ZM_MAX_CH-1:0] pick;
  logic                 free;
  logic                 grant;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 rsp_pop;

  always_comb begin
    vld_ext               = '0;
    vld_ext[NUM_CH-1:0]   = bus.i_req_valid;
    pick = rr_pick(vld_ext, {{(32-ZM_CH_W){1'b0}}, last_grant_q}, 32'(NUM_CH));
  end

  // run_q keeps o_req_ready low until the first edge after reset release.
  assign free   = !mem_valid_q || bus.i_mem_ready;
  assign grant  = run_q && free && !fifo_full && (|bus.i_req_valid);
  assign gnt_oh = grant ? pick[NUM_CH-1:0] : '0;

  always_comb begin
    gnt_id = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (gnt_oh[c]) gnt_id = ch_id_t'(c);
    end
  end

  always_comb begin
    req_d       = '0;
    req_d.write = bus.i_req_write[gnt_id];
    req_d.addr  = bus.i_req_addr[gnt_id*ADDR_W +: ADDR_W];
    req_d.wdata = bus.i_req_wdata[gnt_id*DATA_W +: DATA_W];
    req_d.wmask = bus.i_req_wmask[gnt_id*MASK_W +: MASK_W];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run_q        <= 1'b0;
      mem_valid_q  <= 1'b0;
      req_q        <= '0;
      last_grant_q <= ch_id_t'(NUM_CH - 1);
    end else begin
      run_q <= 1'b1;
      if (grant) begin
        mem_valid_q  <= 1'b1;
        req_q        <= req_d;
        last_grant_q <= gnt_id;
      end else if (bus.i_mem_ready) begin
        mem_valid_q  <= 1'b0;
      end
    end
  end

  zacore_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (ZM_CH_W)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (grant),
    .pop     (rsp_pop),
    .din     (gnt_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // A response with nothing outstanding is dropped and latched as a protocol error.
  assign rsp_pop = bus.i_mem_rsp_valid && !fifo_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (rsp_pop) begin
        rsp_valid_q[fifo_head] <= 1'b1;
        rsp_rdata_q            <= bus.i_mem_rdata;
      end
      if (bus.i_mem_rsp_valid && fifo_empty) err_q <= 1'b1;
    end
  end

  assign bus.o_req_ready = gnt_oh;
  assign bus.o_mem_valid = mem_valid_q;
  assign bus.o_mem_write = req_q.write;
  assign bus.o_mem_addr  = req_q.addr;
  assign bus.o_mem_wdata = req_q.wdata;
  assign bus.o_mem_wmask = req_q.wmask;
  assign bus.o_rsp_valid = rsp_valid_q;
  assign bus.o_rsp_rdata = rsp_rdata_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Directed bench for zacore_mem_arbiter: reset, round-robin, stall, outstanding limit,
// response routing, underflow error and mid-burst reset, all against hand-computed values.
module tb_zacore_mem_arbiter;
  import zacore_mem_pkg::*;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MO  = 4;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  zacore_mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  zacore_mem_arbiter #(
    .NUM_CH    (NCH),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_OUTST (MO)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask);
    bus.i_req_write[ch]          = wr;
    bus.i_req_addr[ch*AW +: AW]  = addr;
    bus.i_req_wdata[ch*DW +: DW] = wdata;
    bus.i_req_wmask[ch*4 +: 4]   = wmask;
  endtask

  logic [1:0]  exp_own [4];
  logic [31:0] exp_alt [4];

  initial begin
    exp_own = '{2'b10, 2'b01, 2'b10, 2'b01};
    exp_alt = '{32'h1000, 32'h2000, 32'h1000, 32'h2000};
    bus.i_req_valid     = '0;
    bus.i_req_write     = '0;
    bus.i_req_addr      = '0;
    bus.i_req_wdata     = '0;
    bus.i_req_wmask     = '0;
    bus.i_mem_ready     = 1'b0;
    bus.i_mem_rsp_valid = 1'b0;
    bus.i_mem_rdata     = '0;

    // reset with both channels requesting
    set_req(0, 1'b0, 32'h1000, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h2000, 32'h0, 4'hF);
    bus.i_req_valid = 2'b11;
    bus.i_mem_ready = 1'b1;
    #12;
    check("rst_ready",     64'(bus.o_req_ready), 64'h0);
    check("rst_mem_valid", 64'(bus.o_mem_valid), 64'h0);
    check("rst_mem_addr",  64'(bus.o_mem_addr),  64'h0);
    check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
    check("rst_rsp_rdata", 64'(bus.o_rsp_rdata), 64'h0);
    check("rst_err",       64'(bus.o_err),       64'h0);
    i_rst_n = 1'b1;
    tick();
    check("first_ready", 64'(bus.o_req_ready), 64'h1);

    // alternation until four requests are in flight
    for (int i = 0; i < 4; i++) begin
      tick();
      check("alt_valid", 64'(bus.o_mem_valid), 64'h1);
      check("alt_addr",  64'(bus.o_mem_addr),  64'(exp_alt[i]));
      check("alt_ready", 64'(bus.o_req_ready), (i == 3) ? 64'h0 : ((i % 2 == 0) ? 64'h2 : 64'h1));
    end
    tick();
    check("full_mem_valid", 64'(bus.o_mem_valid), 64'h0);
    check("full_hold",      64'(bus.o_req_ready), 64'h0);
    bus.i_mem_rsp_valid = 1'b1;
    bus.i_mem_rdata     = 32'h1111_1111;
    #1;
    check("full_no_bypass", 64'(bus.o_req_ready), 64'h0);
    tick();
    bus.i_mem_rsp_valid = 1'b0;
    check("pop_rsp_valid",   64'(bus.o_rsp_valid), 64'h1);
    check("pop_rsp_rdata",   64'(bus.o_rsp_rdata), 64'h1111_1111);
    check("grant_after_pop", 64'(bus.o_req_ready), 64'h1);
    tick();
    check("refill_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
    check("refill_addr",      64'(bus.o_mem_addr),  64'h1000);
    check("refill_ready",     64'(bus.o_req_ready), 64'h0);

    // drain in issue order: ch1, ch0, ch1, ch0
    bus.i_req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bus.i_mem_rsp_valid = 1'b1;
      bus.i_mem_rdata     = 32'hA0 + 32'(i);
      tick();
      check("drain_owner", 64'(bus.o_rsp_valid), 64'(exp_own[i]));
      check("drain_rdata", 64'(bus.o_rsp_rdata), 64'(32'hA0 + 32'(i)));
    end
    bus.i_mem_rsp_valid = 1'b0;
    tick();
    check("strobe_one_cycle", 64'(bus.o_rsp_valid), 64'h0);
    check("drain_mem_valid",  64'(bus.o_mem_valid), 64'h0);

    // backpressure: write from ch1 stalls, second ch1 request waits
    set_req(1, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hA);
    bus.i_mem_ready = 1'b0;
    bus.i_req_valid = 2'b10;
    #1;
    check("bp_first_ready", 64'(bus.o_req_ready), 64'h2);
    tick();
    set_req(1, 1'b0, 32'h2004, 32'h0, 4'hF);
    #1;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 64'(bus.o_mem_valid), 64'h1);
      check("bp_write", 64'(bus.o_mem_write), 64'h1);
      check("bp_addr",  64'(bus.o_mem_addr),  64'h2000);
      check("bp_wdata", 64'(bus.o_mem_wdata), 64'hDEAD_BEEF);
      check("bp_wmask", 64'(bus.o_mem_wmask), 64'hA);
      check("bp_ready", 64'(bus.o_req_ready), 64'h0);
      tick();
    end
    bus.i_mem_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.o_req_ready), 64'h2);
    tick();
    bus.i_req_valid = 2'b00;
    check("bp_accept_addr",  64'(bus.o_mem_addr),  64'h2004);
    check("bp_accept_write", 64'(bus.o_mem_write), 64'h0);

    // write responses still strobe the owner
    bus.i_mem_rsp_valid = 1'b1;
    bus.i_mem_rdata     = 32'h0;
    tick();
    check("wr_rsp0", 64'(bus.o_rsp_valid), 64'h2);
    tick();
    bus.i_mem_rsp_valid = 1'b0;
    check("wr_rsp1", 64'(bus.o_rsp_valid), 64'h2);

    // ch1 read 0x100 then ch0 read 0x200, data routed back in order
    set_req(1, 1'b0, 32'h100, 32'h0, 4'hF);
    bus.i_req_valid = 2'b10;
    tick();
    check("rd1_addr", 64'(bus.o_mem_addr), 64'h100);
    set_req(0, 1'b0, 32'h200, 32'h0, 4'hF);
    bus.i_req_valid = 2'b01;
    #1;
    check("rd0_ready", 64'(bus.o_req_ready), 64'h1);
    tick();
    bus.i_req_valid = 2'b00;
    check("rd0_addr", 64'(bus.o_mem_addr), 64'h200);
    bus.i_mem_rsp_valid = 1'b1;
    bus.i_mem_rdata     = 32'hAAAA_AAAA;
    tick();
    check("rd_rsp_a_owner", 64'(bus.o_rsp_valid), 64'h2);
    check("rd_rsp_a_data",  64'(bus.o_rsp_rdata), 64'hAAAA_AAAA);
    bus.i_mem_rdata = 32'hBBBB_BBBB;
    tick();
    bus.i_mem_rsp_valid = 1'b0;
    check("rd_rsp_b_owner", 64'(bus.o_rsp_valid), 64'h1);
    check("rd_rsp_b_data",  64'(bus.o_rsp_rdata), 64'hBBBB_BBBB);

    // underflow
    check("pre_err", 64'(bus.o_err), 64'h0);
    bus.i_mem_rsp_valid = 1'b1;
    tick();
    bus.i_mem_rsp_valid = 1'b0;
    check("uf_err",       64'(bus.o_err),       64'h1);
    check("uf_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
    tick();
    check("err_sticky",   64'(bus.o_err),       64'h1);
    check("uf_rsp_quiet", 64'(bus.o_rsp_valid), 64'h0);

    // asynchronous reset in the middle of a burst
    set_req(0, 1'b0, 32'h1000, 32'h0, 4'hF);
    set_req(1, 1'b0, 32'h2000, 32'h0, 4'hF);
    bus.i_req_valid = 2'b11;
    tick();
    tick();
    check("burst_valid", 64'(bus.o_mem_valid), 64'h1);
    #3;
    i_rst_n = 1'b0;
    #1;
    check("arst_mem_valid", 64'(bus.o_mem_valid), 64'h0);
    check("arst_mem_addr",  64'(bus.o_mem_addr),  64'h0);
    check("arst_err",       64'(bus.o_err),       64'h0);
    check("arst_ready",     64'(bus.o_req_ready), 64'h0);
    check("arst_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
    tick();
    check("arst_hold_ready", 64'(bus.o_req_ready), 64'h0);
    i_rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(bus.o_req_ready), 64'h1);
    bus.i_req_valid = 2'b00;
    bus.i_mem_rsp_valid = 1'b1;
    tick();
    bus.i_mem_rsp_valid = 1'b0;
    check("post_rst_empty",     64'(bus.o_err),       64'h1);
    check("post_rst_rsp_quiet", 64'(bus.o_rsp_valid), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
